// File: rtl/byte_register_sequencer_if.sv
// byte_register_sequencer_if: command handshake and register-control bundle for the byte register sequencer
interface byte_register_sequencer_if #(parameter int WIDTH = 8, parameter int CNT_W = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             load;
  logic             inc;
  logic             rotate_right;
  logic [WIDTH-1:0] D;
  logic             busy;
  logic             done;
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count,
    input  cmd_ready, load, inc, rotate_right, D, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count,
    output cmd_ready, load, inc, rotate_right, D, busy, done
  );
endinterface

// File: rtl/byte_register_sequencer.sv
// byte_register_sequencer: turns LOAD/INC/ROR commands into consecutive strobes for the byte register
module byte_register_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic                       clk,
  input logic                       reset,
  byte_register_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  localparam logic [1:0] NOP = 2'd0, LOAD = 2'd1, INC = 2'd2, ROR = 2'd3;
  state_t           state_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] d_q;
  always_comb rem_d = bus.cmd_op == LOAD ? CNT_W'(1) : bus.cmd_op == NOP ? '0 : bus.cmd_count;
  assign bus.cmd_ready    = state_q == IDLE && !reset;
  assign bus.busy         = state_q != IDLE;
  assign bus.done         = state_q == DONE;
  assign bus.load         = state_q == ISSUE && op_q == LOAD;
  assign bus.inc          = state_q == ISSUE && op_q == INC;
  assign bus.rotate_right = state_q == ISSUE && op_q == ROR;
  assign bus.D            = d_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= NOP;
      rem_q   <= '0;
      d_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.cmd_valid) begin
          op_q    <= bus.cmd_op;
          rem_q   <= rem_d;
          d_q     <= bus.cmd_op == LOAD ? bus.cmd_data : d_q;
          state_q <= rem_d == '0 ? DONE : ISSUE;
        end
        ISSUE: begin
          rem_q   <= rem_q - CNT_W'(1);
          state_q <= rem_q == CNT_W'(1) ? DONE : ISSUE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
